// File: rtl/reset_request_ctrl.sv
// reset_request_ctrl
// Collects every reset request in the SoC and turns each accepted one into a
// clean raw reset pulse. After the pulse comes a hold-off window in which new
// requests are dropped. A sticky cause register records which source fired.
//
// Optional feature: define RESET_WATCHDOG_EN to build the watchdog timer.
// Without it, wdtEnable/wdtKick are ignored and cause[2] stays 0.
//
// Ports:
//   clk        free-running board clock
//   rst        asynchronous active-high power-on reset
//   btnRst     raw asynchronous push-button, active-high
//   swRstReq   single-cycle software reset strobe (clk domain)
//   wdtEnable  watchdog runs while high
//   wdtKick    single-cycle strobe, restarts the watchdog
//   causeClr   single-cycle strobe, clears cause
//   rstReq     registered reset request pulse, active-high
//   busy       high while a pulse or its hold-off window is in progress
//   cause      sticky {wdt, sw, btn} request flags
module reset_request_ctrl #(
    parameter int DEBOUNCE_BITS  = 16,
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int WDT_BITS       = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnRst,
    input  logic       swRstReq,
    input  logic       wdtEnable,
    input  logic       wdtKick,
    input  logic       causeClr,
    output logic       rstReq,
    output logic       busy,
    output logic [2:0] cause
);

    localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [DEBOUNCE_BITS-1:0] DEB_FULL = {DEBOUNCE_BITS{1'b1}};
    localparam logic [DEBOUNCE_BITS-1:0] DEB_PRE  = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};
    localparam logic [DEBOUNCE_BITS-1:0] DEB_ONE  = DEBOUNCE_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_cnt_nxt;

    logic                     btn_meta_p0;
    logic                     btn_sync_p1;
    logic [DEBOUNCE_BITS-1:0] deb_cnt;
    logic                     btn_evt;
    logic                     sw_evt;
    logic                     wdt_evt;
    logic                     any_evt;
    logic                     in_window;

    logic       rst_req_nxt;
    logic       busy_nxt;
    logic [2:0] cause_set;
    logic [2:0] cause_nxt;

    assign in_window = (state != S_IDLE);

    // Button: two-flop synchronizer, then debounce counter. btn_evt is
    // registered on the cycle the counter reaches all-ones; the counter then
    // saturates, so a fresh event needs a release and a full new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            deb_cnt     <= '0;
            btn_evt     <= 1'b0;
        end else begin
            btn_meta_p0 <= btnRst;
            btn_sync_p1 <= btn_meta_p0;
            btn_evt     <= btn_sync_p1 && (deb_cnt == DEB_PRE);
            if (!btn_sync_p1) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_FULL) begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end
    end

    assign sw_evt = swRstReq;

`ifdef RESET_WATCHDOG_EN
    localparam logic [WDT_BITS-1:0] WDT_PRE = {{(WDT_BITS-1){1'b1}}, 1'b0};
    localparam logic [WDT_BITS-1:0] WDT_ONE = WDT_BITS'(1);

    logic [WDT_BITS-1:0] wdt_cnt;

    // The counter wraps to zero on the same cycle it reaches all-ones, so
    // wdt_evt is a single-cycle pulse and the count never holds all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt <= '0;
            wdt_evt <= 1'b0;
        end else begin
            wdt_evt <= 1'b0;
            if (!wdtEnable || wdtKick || in_window) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt == WDT_PRE) begin
                wdt_cnt <= '0;
                wdt_evt <= 1'b1;
            end else begin
                wdt_cnt <= wdt_cnt + WDT_ONE;
            end
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt = wdtEnable ^ wdtKick;
    assign wdt_evt    = 1'b0;
`endif

    assign any_evt = btn_evt | sw_evt | wdt_evt;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
        end
    end

    // FSM next state: phase_cnt counts down the remaining cycles of the
    // current ASSERT or HOLDOFF phase.
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        case (state)
            S_IDLE: begin
                if (any_evt) begin
                    state_nxt     = S_ASSERT;
                    phase_cnt_nxt = PULSE_LOAD;
                end
            end
            S_ASSERT: begin
                if (phase_cnt == '0) begin
                    state_nxt     = S_HOLDOFF;
                    phase_cnt_nxt = HOLD_LOAD;
                end else begin
                    phase_cnt_nxt = phase_cnt - CNT_ONE;
                end
            end
            S_HOLDOFF: begin
                if (phase_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    phase_cnt_nxt = phase_cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                phase_cnt_nxt = '0;
            end
        endcase
    end

    // FSM outputs: decoded from the next state and registered below, so
    // every output comes straight from a flop. Events are only recorded when
    // accepted in IDLE; a set beats a same-cycle clear.
    always_comb begin
        rst_req_nxt = (state_nxt == S_ASSERT);
        busy_nxt    = (state_nxt != S_IDLE);
        cause_set   = (state == S_IDLE) ? {wdt_evt, sw_evt, btn_evt} : 3'b000;
        cause_nxt   = (causeClr ? 3'b000 : cause) | cause_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstReq <= 1'b0;
            busy   <= 1'b0;
            cause  <= 3'b000;
        end else begin
            rstReq <= rst_req_nxt;
            busy   <= busy_nxt;
            cause  <= cause_nxt;
        end
    end

endmodule
